// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM, press/release strobes.
// Define BUTTON_DEBOUNCE_HOLD_EN to build the long-press (btn_hold) detector.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_hold
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time parameter sanity checks
  if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (HOLD_CYCLES == 0) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end

  // State bit 1 is the accepted level, bit 0 marks a pending (counting) transition.
  typedef enum logic [1:0] {
    StStableLow  = 2'b00,
    StPendHigh   = 2'b01,
    StStableHigh = 2'b10,
    StPendLow    = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic            s1_q, s2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            cnt_done;

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  assign cnt_done = (cnt_q == CntLast);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StStableLow;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStableLow: begin
        // With DEBOUNCE_CYCLES == 1 the first differing sample already completes the count.
        if (s2_q) state_d = cnt_done ? StStableHigh : StPendHigh;
      end
      StPendHigh: begin
        if (!s2_q)         state_d = StStableLow;
        else if (cnt_done) state_d = StStableHigh;
      end
      StStableHigh: begin
        if (!s2_q) state_d = cnt_done ? StStableLow : StPendLow;
      end
      StPendLow: begin
        if (s2_q)          state_d = StStableHigh;
        else if (cnt_done) state_d = StStableLow;
      end
      default: state_d = StStableLow;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and counter next values
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d     = '0;
    level_d   = 1'b0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if ((state_d == StPendHigh) || (state_d == StPendLow)) begin
      cnt_d = cnt_q + CntW'(1);
    end
    level_d   = (state_d == StStableHigh) || (state_d == StPendLow);
    press_d   = ((state_q == StStableLow) || (state_q == StPendHigh)) &&
                (state_d == StStableHigh);
    release_d = ((state_q == StStableHigh) || (state_q == StPendLow)) &&
                (state_d == StStableLow);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

  // ---------------------------------------------------------------------------
  // Long-press detector
  // ---------------------------------------------------------------------------
`ifdef BUTTON_DEBOUNCE_HOLD_EN
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             hold_q, hold_d;

  // Saturating at HOLD_CYCLES keeps the fire condition from recurring within one press.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (!level_q) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HoldMax) begin
      hold_cnt_d = hold_cnt_q + HoldW'(1);
    end
    hold_d = level_q && (hold_cnt_q == HoldLast);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      hold_q     <= hold_d;
    end
  end

  assign btn_hold = hold_q;

  a_hold_cnt_range: assert property (@(posedge clk) disable iff (rst)
    hold_cnt_q <= HoldMax);
  a_hold_single: assert property (@(posedge clk) disable iff (rst)
    btn_hold |=> !btn_hold);
`else
  assign btn_hold = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_strobe_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(btn_press && btn_release));
  a_strobe_spaced: assert property (@(posedge clk) disable iff (rst)
    (btn_press || btn_release) |=> !(btn_press || btn_release));
  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    cnt_q <= CntLast);
  a_level_matches_state: assert property (@(posedge clk) disable iff (rst)
    level_q == state_q[1]);

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8); strobe events
// are queued with their expected cycle and matched as the DUT emits them.
module tb_button_debounce;

  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 8;
  localparam int KPress   = 0;
  localparam int KRelease = 1;
  localparam int KHold    = 2;
`ifdef BUTTON_DEBOUNCE_HOLD_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_level, btn_press, btn_release, btn_hold;

  int   cyc       = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   hold_seen = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_hold   (btn_hold)
  );

  function automatic string kname(input int k);
    case (k)
      KPress:   return "press";
      KRelease: return "release";
      default:  return "hold";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic expect_hold(input int at);
    if (HoldEn) expect_ev(KHold, at);
  endtask

  // Match every strobe seen this cycle against the head of the expectation queue.
  task automatic observe();
    logic [2:0] s;
    s = {btn_hold, btn_release, btn_press};
    if (btn_hold) hold_seen++;
    for (int k = 0; k < 3; k++) begin
      if (s[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_%s: got strobe at cycle %0d, required none", kname(k), cyc);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.kind !== k || e.cyc !== cyc) begin
            errors++;
            $display("FAIL strobe_%s: got %s at cycle %0d, required %s at cycle %0d",
                     kname(k), kname(k), cyc, kname(e.kind), e.cyc);
          end
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      observe();
    end
  endtask

  task automatic drain(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d strobes missing (first %s at cycle %0d), required 0",
               name, exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
    end
    exp_q.delete();
  endtask

  task automatic check_level(input string name, input logic exp);
    checks++;
    if (btn_level !== exp) begin
      errors++;
      $display("FAIL %s: got btn_level=%b at cycle %0d, required %b", name, btn_level, cyc, exp);
    end
  endtask

  task automatic test_reset();
    int k;
    rst    = 1'b1;
    btn_in = 1'b0;
    tick(2);
    checks++;
    if ({btn_level, btn_press, btn_release, btn_hold} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_values: got %b, required 0000",
               {btn_level, btn_press, btn_release, btn_hold});
    end
    rst = 1'b0;
    tick(2);
    btn_in = 1'b1;
    k = cyc;
    expect_ev(KPress, k + 6);
    tick(8);
    check_level("level_before_reset", 1'b1);
    // Mid-cycle reset: outputs must clear with no clock edge in between.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release, btn_hold} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got %b, required 0000",
               {btn_level, btn_press, btn_release, btn_hold});
    end
    tick(3);
    rst = 1'b0;
    k = cyc;
    expect_ev(KPress, k + 6);
    tick(5);
    check_level("reset_no_early_press", 1'b0);
    tick(2);
    check_level("reset_press_level", 1'b1);
    btn_in = 1'b0;
    expect_ev(KRelease, cyc + 6);
    tick(10);
    check_level("reset_release_level", 1'b0);
    drain("reset");
  endtask

  task automatic test_clean_press();
    int k;
    btn_in = 1'b1;
    k = cyc;
    expect_ev(KPress, k + 6);
    expect_hold(k + 14);
    tick(5);
    check_level("clean_not_yet_high", 1'b0);
    tick(1);
    check_level("clean_high", 1'b1);
    tick(14);
    btn_in = 1'b0;
    k = cyc;
    expect_ev(KRelease, k + 6);
    tick(5);
    check_level("clean_still_high", 1'b1);
    tick(1);
    check_level("clean_low", 1'b0);
    tick(4);
    drain("clean");
  endtask

  task automatic test_bounce_reject();
    for (int w = 1; w <= 3; w++) begin
      btn_in = 1'b1;
      tick(w);
      btn_in = 1'b0;
      tick(5);
      check_level($sformatf("glitch_%0d", w), 1'b0);
    end
    tick(4);
    drain("bounce_reject");
  endtask

  task automatic test_bounce_settle();
    int k;
    btn_in = 1'b1; tick(1);
    btn_in = 1'b0; tick(1);
    btn_in = 1'b1; tick(1);
    btn_in = 1'b0; tick(1);
    btn_in = 1'b1;
    k = cyc;
    expect_ev(KPress, k + 6);
    expect_hold(k + 14);
    tick(10);
    check_level("settle_high", 1'b1);
    btn_in = 1'b0;
    expect_ev(KRelease, k + 16);
    tick(12);
    check_level("settle_low", 1'b0);
    drain("bounce_settle");
  endtask

  task automatic test_hold();
    int k;
    hold_seen = 0;
    for (int p = 0; p < 2; p++) begin
      btn_in = 1'b1;
      k = cyc;
      expect_ev(KPress, k + 6);
      expect_hold(k + 14);
      expect_ev(KRelease, k + 36);
      tick(30);
      check_level($sformatf("hold_level_%0d", p), 1'b1);
      btn_in = 1'b0;
      tick(14);
      check_level($sformatf("hold_released_%0d", p), 1'b0);
    end
    checks++;
    if (hold_seen != (HoldEn ? 2 : 0)) begin
      errors++;
      $display("FAIL hold_count: got %0d hold strobes, required %0d",
               hold_seen, HoldEn ? 2 : 0);
    end
    drain("hold");
  endtask

  task automatic test_back_to_back();
    int k;
    k = cyc;
    btn_in = 1'b1;
    expect_ev(KPress, k + 6);
    tick(6);
    btn_in = 1'b0;
    expect_ev(KRelease, k + 12);
    tick(6);
    btn_in = 1'b1;
    expect_ev(KPress, k + 18);
    tick(6);
    btn_in = 1'b0;
    expect_ev(KRelease, k + 24);
    tick(10);
    check_level("b2b_low", 1'b0);
    drain("back_to_back");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_bounce_settle();
    test_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
